// File: rtl/inst_block_memory_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | inst_block_memory_if : cache refill port (read strobe, block, busywait) |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
interface inst_block_memory_if;
  logic         inst_read;
  logic [5:0]   inst_address;
  logic [127:0] inst_readdata;
  logic         inst_busywait;

  modport master (
    output inst_read,
    output inst_address,
    input  inst_readdata,
    input  inst_busywait
  );

  modport slave (
    input  inst_read,
    input  inst_address,
    output inst_readdata,
    output inst_busywait
  );
endinterface
`default_nettype wire

// File: rtl/inst_block_memory.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | inst_block_memory : fixed-latency 64x128 instruction block memory with  |
// | a word-granular program port. Rev 1.0                                   |
// +-------------------------------------------------------------------------+
module inst_block_memory #(
  parameter int LATENCY = 4,
  parameter int BLOCKS  = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  inst_block_memory_if.slave    bus,
  input  logic                  prog_we,
  input  logic [5:0]            prog_block,
  input  logic [1:0]            prog_word,
  input  logic [31:0]           prog_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] C_CNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]   r_state;
  logic [3:0]   r_cnt;
  logic [5:0]   r_addr;
  logic [127:0] r_readdata;
  logic [127:0] r_mem [BLOCKS];
  logic         w_busywait;

  // Array has no reset so a preloaded program survives a reset pulse.
  always_ff @(posedge clock) begin
    if (prog_we) begin
      r_mem[prog_block][{prog_word, 5'b00000} +: 32] <= prog_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_addr     <= 6'd0;
      r_readdata <= 128'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.inst_read) begin
            r_addr  <= bus.inst_address;
            r_cnt   <= C_CNT_LOAD;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            // Non-blocking read sees pre-write contents on a colliding edge.
            r_readdata <= r_mem[r_addr];
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Rises in the request cycle so the cache never samples a stale 0.
  assign w_busywait = ((r_state == S_IDLE) && bus.inst_read) || (r_state == S_BUSY);

  assign bus.inst_busywait = w_busywait;
  assign bus.inst_readdata = r_readdata;

endmodule
`default_nettype wire

// File: tb/tb_inst_block_memory.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_inst_block_memory : scoreboard bench, LATENCY=4 and LATENCY=1 DUTs   |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_inst_block_memory;

  localparam int LAT = 4;

  localparam logic [127:0] B5   = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] B5W  = 128'h44444444_DEADBEEF_22222222_11111111;
  localparam logic [127:0] B63  = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
  localparam logic [127:0] B9   = 128'h99999999_88888888_77777777_66666666;
  localparam logic [127:0] B0L1 = 128'h0F0F0F0F_CAFEF00D_89ABCDEF_01234567;

  logic clock = 1'b0;
  logic reset;
  logic        prog_we,  p1_we;
  logic [5:0]  prog_block, p1_block;
  logic [1:0]  prog_word,  p1_word;
  logic [31:0] prog_data,  p1_data;

  int checks = 0;
  int errors = 0;
  logic [127:0] q0[$];
  logic [127:0] q1[$];
  logic [127:0] last_data = 128'h0;

  inst_block_memory_if bus0 ();
  inst_block_memory_if bus1 ();

  inst_block_memory #(.LATENCY(LAT), .BLOCKS(64)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus0),
    .prog_we    (prog_we),
    .prog_block (prog_block),
    .prog_word  (prog_word),
    .prog_data  (prog_data)
  );

  inst_block_memory #(.LATENCY(1), .BLOCKS(64)) dut1 (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus1),
    .prog_we    (p1_we),
    .prog_block (p1_block),
    .prog_word  (p1_word),
    .prog_data  (p1_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Completion is visible as busywait low while the request is still held.
  always @(negedge clock) begin
    if (!reset && bus0.inst_read === 1'b1 && bus0.inst_busywait === 1'b0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp0: got %h expected none", bus0.inst_readdata);
      end else begin
        check("resp0", bus0.inst_readdata, q0.pop_front());
      end
    end
    if (!reset && bus1.inst_read === 1'b1 && bus1.inst_busywait === 1'b0) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp1: got %h expected none", bus1.inst_readdata);
      end else begin
        check("resp1", bus1.inst_readdata, q1.pop_front());
      end
    end
  end

  task automatic prog_write(input logic [5:0] blk, input logic [1:0] w, input logic [31:0] d);
    prog_we = 1'b1; prog_block = blk; prog_word = w; prog_data = d;
    @(posedge clock); #1;
    prog_we = 1'b0;
  endtask

  task automatic prog_block_all(input logic [5:0] blk, input logic [127:0] v);
    for (int w = 0; w < 4; w++) prog_write(blk, 2'(w), v[32*w +: 32]);
  endtask

  // Called #1 after a posedge with the DUT idle.
  task automatic do_read(input logic [5:0] a, input logic [127:0] exp, input bit chg, input bit coll);
    int n;
    bus0.inst_read = 1'b1;
    bus0.inst_address = a;
    q0.push_back(exp);
    #1;
    check("bw_rise", {127'd0, bus0.inst_busywait}, 128'd1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      prog_we = 1'b0;
      if (!bus0.inst_busywait) break;
      n++;
      if (n == 1) check("hold_prev", bus0.inst_readdata, last_data);
      if (chg && n == 1) bus0.inst_address = 6'd9;
      if (coll && n == LAT) begin
        prog_we = 1'b1; prog_block = 6'd5; prog_word = 2'd2; prog_data = 32'hDEADBEEF;
      end
    end
    check("bw_cycles", 128'(n), 128'(LAT));
    @(posedge clock); #1;
    bus0.inst_read = 1'b0;
    last_data = exp;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus0.inst_read = 1'b0; bus0.inst_address = 6'd0;
    bus1.inst_read = 1'b0; bus1.inst_address = 6'd0;
    prog_we = 1'b0; prog_block = 6'd0; prog_word = 2'd0; prog_data = 32'd0;
    p1_we = 1'b0; p1_block = 6'd0; p1_word = 2'd0; p1_data = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("reset_readdata", bus0.inst_readdata, 128'h0);
    check("reset_busywait", {127'd0, bus0.inst_busywait}, 128'd0);

    prog_block_all(6'd5, B5);
    prog_block_all(6'd63, B63);
    prog_block_all(6'd9, B9);

    // Abort: reset lands during the second BUSY cycle.
    bus0.inst_read = 1'b1; bus0.inst_address = 6'd5;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1; bus0.inst_read = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    check("abort_readdata", bus0.inst_readdata, 128'h0);
    check("abort_busywait", {127'd0, bus0.inst_busywait}, 128'd0);
    @(posedge clock); #1;
    check("abort_readdata_idle", bus0.inst_readdata, 128'h0);

    do_read(6'd5, B5, 1'b0, 1'b0);
    do_read(6'd5, B5, 1'b0, 1'b0);
    do_read(6'd63, B63, 1'b0, 1'b0);
    check("hold_idle", bus0.inst_readdata, B63);
    do_read(6'd5, B5, 1'b1, 1'b0);
    do_read(6'd5, B5, 1'b0, 1'b1);
    do_read(6'd5, B5W, 1'b0, 1'b0);
    do_read(6'd9, B9, 1'b0, 1'b0);

    for (int w = 0; w < 4; w++) begin
      p1_we = 1'b1; p1_block = 6'd0; p1_word = 2'(w); p1_data = B0L1[32*w +: 32];
      @(posedge clock); #1;
    end
    p1_we = 1'b0;
    bus1.inst_read = 1'b1; bus1.inst_address = 6'd0;
    q1.push_back(B0L1);
    #1;
    check("l1_bw_rise", {127'd0, bus1.inst_busywait}, 128'd1);
    @(posedge clock); #1;
    check("l1_bw_busy", {127'd0, bus1.inst_busywait}, 128'd1);
    @(posedge clock); #1;
    check("l1_bw_done", {127'd0, bus1.inst_busywait}, 128'd0);
    check("l1_data", bus1.inst_readdata, B0L1);
    @(posedge clock); #1;
    bus1.inst_read = 1'b0;

    repeat (3) @(posedge clock);
    check("sb0_drained", 128'(q0.size()), 128'd0);
    check("sb1_drained", 128'(q1.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
